// File: rtl/bp_me_trace_arbiter.sv
// bp_me_trace_arbiter
// Shares one trace-packet port of the mock LCE/ME between num_req_p trace
// node masters. Round-robin grant with a lock that holds the downstream
// packet stable until it is consumed. An in-order tag FIFO remembers the
// requester of every issued packet so that returned packets are steered
// back to the master that sent them.
module bp_me_trace_arbiter #(
  parameter int num_req_p         = 2,
  parameter int ring_width_p      = 64,
  parameter int max_outstanding_p = 4
) (
  input  logic                              clk_i,
  input  logic                              reset_i,

  input  logic [num_req_p*ring_width_p-1:0] req_pkt_i,
  input  logic [num_req_p-1:0]              req_v_i,
  output logic [num_req_p-1:0]              req_yumi_o,

  output logic [ring_width_p-1:0]           resp_pkt_o,
  output logic [num_req_p-1:0]              resp_v_o,
  input  logic [num_req_p-1:0]              resp_ready_i,

  output logic [ring_width_p-1:0]           tr_pkt_o,
  output logic                              tr_pkt_v_o,
  input  logic                              tr_pkt_yumi_i,

  input  logic [ring_width_p-1:0]           tr_pkt_i,
  input  logic                              tr_pkt_v_i,
  output logic                              tr_pkt_ready_o,

  output logic                              error_o
);

  localparam int id_w  = (num_req_p > 1) ? $clog2(num_req_p) : 1;
  localparam int ptr_w = (max_outstanding_p > 1) ? $clog2(max_outstanding_p) : 1;
  localparam int cnt_w = $clog2(max_outstanding_p + 1);

  localparam logic [cnt_w-1:0] cnt_max  = cnt_w'(max_outstanding_p);
  localparam logic [id_w-1:0]  id_last  = id_w'(num_req_p - 1);
  localparam logic [ptr_w-1:0] ptr_last = ptr_w'(max_outstanding_p - 1);
  localparam logic [id_w:0]    scan_lim = (id_w + 1)'(num_req_p);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  state_e            state_r;
  state_e            state_n;
  logic [id_w-1:0]   grant_r;
  logic [id_w-1:0]   grant_n;
  logic [id_w-1:0]   rr_r;
  logic [id_w-1:0]   rr_n;

  // Tag FIFO: requester IDs of issued-but-unreturned packets, oldest at rd_ptr_r.
  logic [id_w-1:0]   tag_mem_r [max_outstanding_p];
  logic [ptr_w-1:0]  wr_ptr_r;
  logic [ptr_w-1:0]  rd_ptr_r;
  logic [cnt_w-1:0]  count_r;
  logic              error_r;

  logic [ring_width_p-1:0] req_pkt_a [num_req_p];

  logic              pick_v;
  logic [id_w-1:0]   pick_id;
  logic [id_w:0]     scan;
  logic              sel_v;
  logic [id_w-1:0]   sel_id;
  logic              push;
  logic              pop;
  logic              spurious;
  logic              empty;
  logic              full;
  logic [id_w-1:0]   head_id;

  // Unpack the flat request bus into one packet per requester.
  for (genvar gi = 0; gi < num_req_p; gi++) begin : g_unpack
    assign req_pkt_a[gi] = req_pkt_i[gi*ring_width_p +: ring_width_p];
  end

  assign empty   = (count_r == {cnt_w{1'b0}});
  assign full    = (count_r == cnt_max);
  assign head_id = tag_mem_r[rd_ptr_r];
  // Error flag reads as clear for the whole time reset is held.
  assign error_o = error_r & ~reset_i;

  // Round-robin pick: first valid requester at or above rr_r, wrapping.
  // Scanning from the far end down lets the nearest candidate win last.
  always_comb begin
    pick_v  = 1'b0;
    pick_id = {id_w{1'b0}};
    scan    = {(id_w + 1){1'b0}};
    for (int i = num_req_p - 1; i >= 0; i--) begin
      scan = {1'b0, rr_r} + (id_w + 1)'(i);
      if (scan >= scan_lim) begin
        scan = scan - scan_lim;
      end else begin
        scan = scan;
      end
      if (req_v_i[scan[id_w-1:0]]) begin
        pick_v  = 1'b1;
        pick_id = scan[id_w-1:0];
      end else begin
        pick_v  = pick_v;
        pick_id = pick_id;
      end
    end
  end

  // Grant FSM: next state, downstream packet drive and request consumption.
  always_comb begin
    state_n    = state_r;
    grant_n    = grant_r;
    rr_n       = rr_r;
    sel_v      = 1'b0;
    sel_id     = grant_r;
    push       = 1'b0;
    tr_pkt_v_o = 1'b0;
    tr_pkt_o   = {ring_width_p{1'b0}};
    req_yumi_o = {num_req_p{1'b0}};
    if (reset_i) begin
      state_n = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          // Registered full blocks a new grant even if a pop happens now.
          if (pick_v && !full) begin
            sel_v  = 1'b1;
            sel_id = pick_id;
            if (tr_pkt_yumi_i) begin
              push = 1'b1;
            end else begin
              state_n = ST_LOCKED;
              grant_n = pick_id;
            end
          end else begin
            sel_v = 1'b0;
          end
        end
        ST_LOCKED: begin
          // Hold the granted master's packet until the ME consumes it.
          sel_v  = 1'b1;
          sel_id = grant_r;
          if (tr_pkt_yumi_i) begin
            push    = 1'b1;
            state_n = ST_IDLE;
          end else begin
            state_n = ST_LOCKED;
          end
        end
        default: begin
          state_n = ST_IDLE;
        end
      endcase

      if (sel_v) begin
        tr_pkt_v_o = 1'b1;
        tr_pkt_o   = req_pkt_a[sel_id];
      end else begin
        tr_pkt_v_o = 1'b0;
      end

      if (push) begin
        req_yumi_o[sel_id] = 1'b1;
        rr_n = (sel_id == id_last) ? {id_w{1'b0}} : (sel_id + id_w'(1));
      end else begin
        rr_n = rr_r;
      end
    end
  end

  // Response routing: steer the returned packet to the head-of-FIFO owner.
  always_comb begin
    resp_v_o       = {num_req_p{1'b0}};
    resp_pkt_o     = {ring_width_p{1'b0}};
    tr_pkt_ready_o = 1'b0;
    pop            = 1'b0;
    spurious       = 1'b0;
    if (reset_i) begin
      tr_pkt_ready_o = 1'b0;
    end else begin
      resp_pkt_o = tr_pkt_i;
      if (!empty) begin
        resp_v_o[head_id] = tr_pkt_v_i;
        tr_pkt_ready_o    = resp_ready_i[head_id];
        pop               = tr_pkt_v_i & resp_ready_i[head_id];
      end else begin
        // Nobody owns this packet: swallow it and flag the error.
        tr_pkt_ready_o = 1'b1;
        spurious       = tr_pkt_v_i;
      end
    end
  end

  // FSM, grant and round-robin pointer registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r <= ST_IDLE;
      grant_r <= {id_w{1'b0}};
      rr_r    <= {id_w{1'b0}};
    end else begin
      state_r <= state_n;
      grant_r <= grant_n;
      rr_r    <= rr_n;
    end
  end

  // Tag FIFO pointers and occupancy; push and pop together leave count alone.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_r <= {ptr_w{1'b0}};
      rd_ptr_r <= {ptr_w{1'b0}};
      count_r  <= {cnt_w{1'b0}};
    end else begin
      if (push) begin
        wr_ptr_r <= (wr_ptr_r == ptr_last) ? {ptr_w{1'b0}} : (wr_ptr_r + ptr_w'(1));
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop) begin
        rd_ptr_r <= (rd_ptr_r == ptr_last) ? {ptr_w{1'b0}} : (rd_ptr_r + ptr_w'(1));
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({push, pop})
        2'b10:   count_r <= count_r + cnt_w'(1);
        2'b01:   count_r <= count_r - cnt_w'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Tag FIFO storage; contents are don't-care while the FIFO is empty.
  always_ff @(posedge clk_i) begin
    if (push) begin
      tag_mem_r[wr_ptr_r] <= sel_id;
    end else begin
      tag_mem_r[wr_ptr_r] <= tag_mem_r[wr_ptr_r];
    end
  end

  // Sticky error on a response that arrives with no outstanding tag.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      error_r <= 1'b0;
    end else if (spurious) begin
      error_r <= 1'b1;
    end else begin
      error_r <= error_r;
    end
  end

endmodule

// File: tb/tb_bp_me_trace_arbiter.sv
// Randomized self-checking bench for bp_me_trace_arbiter.
// Masters hold valid until consumed; a queue-based ME returns packets in order.
// A transaction-level model (lock id, rr pointer, queue of owner tags) predicts
// every output each cycle.
module tb_bp_me_trace_arbiter;

  localparam int N   = 2;
  localparam int W   = 64;
  localparam int MAX = 4;

  logic             clk_i = 1'b0;
  logic             reset_i;
  logic [N*W-1:0]   req_pkt_i;
  logic [N-1:0]     req_v_i;
  logic [N-1:0]     req_yumi_o;
  logic [W-1:0]     resp_pkt_o;
  logic [N-1:0]     resp_v_o;
  logic [N-1:0]     resp_ready_i;
  logic [W-1:0]     tr_pkt_o;
  logic             tr_pkt_v_o;
  logic             tr_pkt_yumi_i;
  logic [W-1:0]     tr_pkt_i;
  logic             tr_pkt_v_i;
  logic             tr_pkt_ready_o;
  logic             error_o;

  always #5 clk_i = ~clk_i;

  bp_me_trace_arbiter #(
    .num_req_p(N), .ring_width_p(W), .max_outstanding_p(MAX)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .req_pkt_i(req_pkt_i), .req_v_i(req_v_i), .req_yumi_o(req_yumi_o),
    .resp_pkt_o(resp_pkt_o), .resp_v_o(resp_v_o), .resp_ready_i(resp_ready_i),
    .tr_pkt_o(tr_pkt_o), .tr_pkt_v_o(tr_pkt_v_o), .tr_pkt_yumi_i(tr_pkt_yumi_i),
    .tr_pkt_i(tr_pkt_i), .tr_pkt_v_i(tr_pkt_v_i), .tr_pkt_ready_o(tr_pkt_ready_o),
    .error_o(error_o)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model state
  int        m_lock;
  int        m_rr;
  int        m_tags[$];
  bit        m_err;

  // Bench masters and ME
  bit          mv [N];
  logic [W-1:0] mp [N];
  logic [W-1:0] me_q[$];

  // Decisions from the previous cycle, applied after the clock edge
  int d_g;
  bit d_fire;
  bit d_pop;
  bit d_spur;
  bit d_rst;

  // Stimulus knobs
  bit          rst_req;
  bit          force_spur;
  int unsigned req_rate;
  int unsigned yumi_rate;
  int unsigned ret_rate;
  int unsigned rdy_rate;

  task automatic model_reset();
    m_lock = -1;
    m_rr   = 0;
    m_tags.delete();
    m_err  = 1'b0;
    me_q.delete();
  endtask

  task automatic set_rates(input int unsigned rq, input int unsigned yu,
                           input int unsigned rt, input int unsigned rd);
    req_rate  = rq;
    yumi_rate = yu;
    ret_rate  = rt;
    rdy_rate  = rd;
  endtask

  task automatic run_cycles(input int n);
    for (int c = 0; c < n; c++) begin
      int g;
      int h;
      bit found;
      logic [N-1:0] e_yumi;
      logic [N-1:0] e_resp_v;
      bit e_ready;

      @(posedge clk_i);
      #1;
      // Advance the model with what happened at this edge.
      if (d_rst) begin
        model_reset();
      end else begin
        if (d_pop) begin
          void'(m_tags.pop_front());
          void'(me_q.pop_front());
        end
        if (d_fire) begin
          m_tags.push_back(d_g);
          me_q.push_back(mp[d_g]);
          m_rr   = (d_g + 1) % N;
          m_lock = -1;
          mv[d_g] = 1'b0;
        end else if (d_g >= 0) begin
          m_lock = d_g;
        end
        if (d_spur) m_err = 1'b1;
      end

      // New stimulus for this cycle.
      reset_i = rst_req;
      for (int i = 0; i < N; i++) begin
        if (!mv[i] && ($urandom_range(99) < req_rate)) begin
          mv[i] = 1'b1;
          mp[i] = {$urandom, $urandom};
          mp[i][W-1:W-4] = 4'(i);
        end
        req_v_i[i] = mv[i];
        req_pkt_i[i*W +: W] = mp[i];
        resp_ready_i[i] = ($urandom_range(99) < rdy_rate);
      end
      tr_pkt_yumi_i = ($urandom_range(99) < yumi_rate);
      if ((me_q.size() > 0) && ($urandom_range(99) < ret_rate)) begin
        tr_pkt_v_i = 1'b1;
        tr_pkt_i   = me_q[0];
      end else if (force_spur && (me_q.size() == 0)) begin
        tr_pkt_v_i = 1'b1;
        tr_pkt_i   = {$urandom, $urandom};
      end else begin
        tr_pkt_v_i = 1'b0;
        tr_pkt_i   = {$urandom, $urandom};
      end
      #2;

      // Predict outputs from the model.
      g        = -1;
      h        = 0;
      found    = 1'b0;
      e_yumi   = '0;
      e_resp_v = '0;
      e_ready  = 1'b0;
      d_fire   = 1'b0;
      d_pop    = 1'b0;
      d_spur   = 1'b0;
      d_rst    = reset_i;
      if (!reset_i) begin
        if (m_lock >= 0) begin
          g = m_lock;
        end else if (m_tags.size() < MAX) begin
          for (int k = 0; k < N; k++) begin
            if (!found && mv[(m_rr + k) % N]) begin
              g = (m_rr + k) % N;
              found = 1'b1;
            end
          end
        end
        d_fire = (g >= 0) && tr_pkt_yumi_i;
        if (d_fire) e_yumi[g] = 1'b1;
        if (m_tags.size() > 0) begin
          h = m_tags[0];
          e_resp_v[h] = tr_pkt_v_i;
          e_ready     = resp_ready_i[h];
          d_pop       = tr_pkt_v_i && resp_ready_i[h];
        end else begin
          e_ready = 1'b1;
          d_spur  = tr_pkt_v_i;
        end
      end
      d_g = g;

      check_val("req_yumi", 64'(req_yumi_o), 64'(e_yumi));
      check_val("tr_pkt_v", 64'(tr_pkt_v_o), 64'(g >= 0));
      if (g >= 0) check_val("tr_pkt", tr_pkt_o, mp[g]);
      check_val("resp_v", 64'(resp_v_o), 64'(e_resp_v));
      check_val("tr_ready", 64'(tr_pkt_ready_o), 64'(e_ready));
      check_val("error", 64'(error_o), 64'(!reset_i && m_err));
      if (!reset_i && tr_pkt_v_i) check_val("resp_pkt", resp_pkt_o, tr_pkt_i);
    end
  endtask

  initial begin
    reset_i       = 1'b1;
    req_pkt_i     = '0;
    req_v_i       = '0;
    resp_ready_i  = '0;
    tr_pkt_yumi_i = 1'b0;
    tr_pkt_i      = '0;
    tr_pkt_v_i    = 1'b0;
    for (int i = 0; i < N; i++) begin
      mv[i] = 1'b0;
      mp[i] = '0;
    end
    model_reset();
    d_g = -1; d_fire = 1'b0; d_pop = 1'b0; d_spur = 1'b0; d_rst = 1'b1;
    force_spur = 1'b0;

    // Reset: every output must be quiet.
    rst_req = 1'b1;
    set_rates(50, 50, 50, 50);
    run_cycles(3);
    rst_req = 1'b0;

    // Mixed traffic
    set_rates(50, 60, 50, 70);
    run_cycles(600);
    // Continuous contention, no backpressure: alternating grants
    set_rates(100, 100, 80, 100);
    run_cycles(300);
    // Slow returns: FIFO fills and grants stall
    set_rates(100, 80, 10, 50);
    run_cycles(400);
    // Heavy downstream and response backpressure
    set_rates(70, 15, 60, 30);
    run_cycles(400);

    // Drain everything, then inject responses nobody asked for.
    set_rates(0, 100, 100, 100);
    run_cycles(40);
    force_spur = 1'b1;
    set_rates(0, 100, 0, 100);
    run_cycles(3);
    force_spur = 1'b0;
    run_cycles(5);
    check_val("err_sticky", 64'(error_o), 64'(1'b1));

    // Reset in the middle of traffic clears everything including the error.
    set_rates(80, 50, 50, 60);
    run_cycles(50);
    rst_req = 1'b1;
    run_cycles(2);
    rst_req = 1'b0;
    run_cycles(300);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
